// File: rtl/led_mode_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_mode_arbiter_pkg
//  Description : Shared state encoding and wig-wag mask helpers for the
//                car-alarm LED bank arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_mode_arbiter_pkg;

    // Display owner of the LED bank; the encoding is visible on o_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_ALARM = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Widest LED bank the mask helpers can describe.
    localparam int c_max_leds = 64;

    // Even-index LEDs lit (...0101), bits at or above n forced dark.
    function automatic logic [c_max_leds-1:0] even_mask(input int n);
        logic [c_max_leds-1:0] m;
        m = '0;
        for (int i = 0; i < c_max_leds; i++) begin
            m[i] = (i < n) && ((i % 2) == 0);
        end
        return m;
    endfunction

    // Odd-index LEDs lit (...1010), bits at or above n forced dark.
    function automatic logic [c_max_leds-1:0] odd_mask(input int n);
        logic [c_max_leds-1:0] m;
        m = '0;
        for (int i = 0; i < c_max_leds; i++) begin
            m[i] = (i < n) && ((i % 2) == 1);
        end
        return m;
    endfunction

endpackage : led_mode_arbiter_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Blink half-period tick generator. Counts 0..BLINK_HALF-1 and
//                pulses o_tick for one cycle on the wrap; i_clear restarts it
//                so the first tick lands BLINK_HALF cycles after a clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int BLINK_HALF = 2500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_cnt_w = $clog2(BLINK_HALF) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BLINK_HALF - 1);

    logic [c_cnt_w-1:0] cnt_q;

    assign o_tick = (cnt_q == c_last);

    // Half-period counter: wraps on the tick, restarts on a state entry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_clear || o_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + c_cnt_w'(1);
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_mode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : led_mode_arbiter
//  Description : Shares the LED bank between the bouncer (idle), the arm/
//                disarm acknowledge blink and the latched alarm wig-wag, with
//                a dark hold-off after an alarm clear. Alarm > ack > bouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_mode_arbiter
    import led_mode_arbiter_pkg::*;
#(
    parameter int NLEDS      = 8,
    parameter int BLINK_HALF = 2500000,
    parameter int ACK_BLINKS = 3,
    parameter int ALARM_MIN  = 8,
    parameter int HOLD_TICKS = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_bounce_led,
    input  logic             i_alarm_req,
    input  logic             i_alarm_clr,
    input  logic             i_ack_valid,
    output logic             o_ack_ready,
    output logic [NLEDS-1:0] o_led,
    output logic [1:0]       o_state,
    output logic             o_alarm_latched
);

    localparam int c_blink_w = $clog2(ACK_BLINKS) + 1;
    // One tick counter serves both the alarm minimum and the hold-off.
    localparam int c_cnt_max = (ALARM_MIN > HOLD_TICKS) ? ALARM_MIN : HOLD_TICKS;
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

    localparam logic [c_max_leds-1:0] c_even_full = even_mask(NLEDS);
    localparam logic [c_max_leds-1:0] c_odd_full  = odd_mask(NLEDS);
    localparam logic [NLEDS-1:0]      c_even      = c_even_full[NLEDS-1:0];
    localparam logic [NLEDS-1:0]      c_odd       = c_odd_full[NLEDS-1:0];

    localparam logic [c_blink_w-1:0] c_blinks    = c_blink_w'(ACK_BLINKS);
    localparam logic [c_cnt_w-1:0]   c_alarm_min = c_cnt_w'(ALARM_MIN);
    localparam logic [c_cnt_w-1:0]   c_hold_last = c_cnt_w'(HOLD_TICKS - 1);

    state_t               state_q, state_d;
    logic                 phase_q, phase_d;
    logic [c_blink_w-1:0] blink_q, blink_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic [NLEDS-1:0]     led_q,   led_d;
    logic                 w_tick;
    logic                 w_clear;

    // Every state change restarts the tick timebase.
    assign w_clear = (state_d != state_q);

    led_tick_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    assign o_ack_ready     = (state_q == ST_IDLE) && !i_alarm_req;
    assign o_state         = state_q;
    assign o_alarm_latched = (state_q == ST_ALARM);
    assign o_led           = led_q;

    // State, phase, counters and the registered LED drive.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            blink_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    // Next-state and counter updates; alarm requests pre-empt everything.
    always_comb begin
        state_d = state_q;
        phase_d = w_tick ? ~phase_q : phase_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_alarm_req) begin
                    state_d = ST_ALARM;
                    phase_d = 1'b1;
                    cnt_d   = '0;
                end else if (i_ack_valid) begin
                    state_d = ST_ACK;
                    phase_d = 1'b1;
                    blink_d = c_blinks;
                end
            end
            ST_ACK: begin
                if (i_alarm_req) begin
                    state_d = ST_ALARM;
                    phase_d = 1'b1;
                    cnt_d   = '0;
                end else if (w_tick && !phase_q) begin
                    // Only the dark->lit edge closes a blink pair.
                    blink_d = blink_q - c_blink_w'(1);
                    if (blink_q == c_blink_w'(1)) begin
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                    end
                end
            end
            ST_ALARM: begin
                if (w_tick && (cnt_q != c_alarm_min)) begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
                if (i_alarm_clr && !i_alarm_req && (cnt_q == c_alarm_min)) begin
                    state_d = ST_HOLD;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin // ST_HOLD
                if (i_alarm_req) begin
                    state_d = ST_ALARM;
                    phase_d = 1'b1;
                    cnt_d   = '0;
                end else if (w_tick) begin
                    if (cnt_q == c_hold_last) begin
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
                end
            end
        endcase
    end

    // LED pattern for the current owner, registered on the next edge.
    always_comb begin
        led_d = '0;
        case (state_q)
            ST_IDLE:  led_d = i_bounce_led;
            ST_ACK:   led_d = phase_q ? '1 : '0;
            ST_ALARM: led_d = phase_q ? c_even : c_odd;
            default:  led_d = '0;
        endcase
    end

endmodule : led_mode_arbiter
`default_nettype wire

// File: tb/tb_led_mode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_mode_arbiter
//  Description : Self-checking bench for led_mode_arbiter. A time-in-state
//                reference model predicts state, LEDs, ready and latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode_arbiter;

    localparam int NL = 8;
    localparam int BH = 4;
    localparam int AB = 2;
    localparam int AM = 3;
    localparam int HT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NL-1:0] bounce = '0;
    logic          req = 1'b0;
    logic          clr = 1'b0;
    logic          ack = 1'b0;
    logic          ready;
    logic [NL-1:0] led;
    logic [1:0]    st;
    logic          latched;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state plus cycles elapsed since entering it.
    int            m_state = 0;
    int            m_el    = 0;
    logic [NL-1:0] m_led   = '0;

    led_mode_arbiter #(
        .NLEDS      (NL),
        .BLINK_HALF (BH),
        .ACK_BLINKS (AB),
        .ALARM_MIN  (AM),
        .HOLD_TICKS (HT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_bounce_led    (bounce),
        .i_alarm_req     (req),
        .i_alarm_clr     (clr),
        .i_ack_valid     (ack),
        .o_ack_ready     (ready),
        .o_led           (led),
        .o_state         (st),
        .o_alarm_latched (latched)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        logic [1:0] s;
        s = m_state[1:0];
        return {s, (m_state == 2), (m_state == 0) && !req, m_led};
    endfunction

    function automatic logic [11:0] act_vec();
        return {st, latched, ready, led};
    endfunction

    // One clock edge: advance the model from the inputs seen at the edge.
    task automatic step();
        int nxt;
        @(posedge clk);
        case (m_state)
            0:       m_led = bounce;
            1:       m_led = (((m_el / BH) % 2) == 0) ? 8'hFF : 8'h00;
            2:       m_led = (((m_el / BH) % 2) == 0) ? 8'h55 : 8'hAA;
            default: m_led = 8'h00;
        endcase
        nxt = m_state;
        case (m_state)
            0: if (req) nxt = 2; else if (ack) nxt = 1;
            1: if (req) nxt = 2; else if (m_el + 1 == 2 * AB * BH) nxt = 0;
            2: if (clr && !req && (m_el / BH) >= AM) nxt = 3;
            default: if (req) nxt = 2; else if (m_el + 1 == HT * BH) nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_state = nxt;
            m_el    = 0;
        end else begin
            m_el++;
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = 1'b0; clr = 1'b0; ack = 1'b0; bounce = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; m_el = 0; m_led = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; clr = 1'b0; ack = 1'b0; bounce = 8'hC3;
        #3;
        n_checks++;
        if (act_vec() !== 12'h100) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", act_vec(), 12'h100);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (act_vec() !== 12'h100) begin
            n_fail++;
            $display("FAIL reset_held got=%h exp=%h", act_vec(), 12'h100);
        end
        rst = 1'b0;
        m_state = 0; m_el = 0; m_led = '0;
    endtask

    task automatic test_idle_passthrough();
        logic [NL-1:0] pats [3];
        pats[0] = 8'h10; pats[1] = 8'h3C; pats[2] = 8'h81;
        for (int i = 0; i < 3; i++) begin
            bounce = pats[i];
            step();
            n_checks++;
            if (led !== pats[i] || st !== 2'd0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_pass got led=%h st=%0d rdy=%b exp led=%h st=0 rdy=1",
                         led, st, ready, pats[i]);
            end
        end
    endtask

    task automatic test_ack();
        int in_ack = 0;
        bounce = 8'h24;
        ack = 1'b1;
        step();
        ack = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (st == 2'd1) in_ack++;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ack_seq cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
            step();
        end
        n_checks++;
        if (in_ack != 2 * AB * BH) begin
            n_fail++;
            $display("FAIL ack_len got=%0d exp=%0d", in_ack, 2 * AB * BH);
        end
        n_checks++;
        if (led !== 8'h24 || st !== 2'd0) begin
            n_fail++;
            $display("FAIL ack_resume got led=%h st=%0d exp led=24 st=0", led, st);
        end
    endtask

    task automatic test_preempt();
        reset_dut();
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (5) step();
        req = 1'b1;
        step();
        n_checks++;
        if (st !== 2'd2 || latched !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_state got st=%0d lat=%b exp st=2 lat=1", st, latched);
        end
        step();
        n_checks++;
        if (led !== 8'h55) begin
            n_fail++;
            $display("FAIL preempt_led got=%h exp=55", led);
        end
    endtask

    task automatic test_priority();
        reset_dut();
        req = 1'b1;
        ack = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ready got=%b exp=0", ready);
        end
        step();
        ack = 1'b0;
        n_checks++;
        if (st !== 2'd2) begin
            n_fail++;
            $display("FAIL prio_state got=%0d exp=2", st);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL prio_seq cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear_gating();
        int hold_cyc = 0;
        reset_dut();
        req = 1'b1;
        step();
        req = 1'b0;
        for (int c = 0; c < 40 && m_el < 2 * BH; c++) begin
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clr_run cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (st !== 2'd2 || latched !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_early got st=%0d lat=%b exp st=2 lat=1", st, latched);
        end
        for (int c = 0; c < 40 && m_el < AM * BH; c++) begin
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clr_wait cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        bounce = 8'h5A;
        n_checks++;
        if (st !== 2'd3 || latched !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_honour got st=%0d lat=%b exp st=3 lat=0", st, latched);
        end
        for (int c = 0; c < 12; c++) begin
            if (st == 2'd3) hold_cyc++;
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_seq cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (hold_cyc != HT * BH) begin
            n_fail++;
            $display("FAIL hold_len got=%0d exp=%0d", hold_cyc, HT * BH);
        end
    endtask

    task automatic test_retrigger();
        reset_dut();
        req = 1'b1;
        step();
        req = 1'b0;
        for (int c = 0; c < 40 && m_el < AM * BH; c++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (3) step();
        req = 1'b1;
        step();
        req = 1'b0;
        n_checks++;
        if (st !== 2'd2 || latched !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_state got st=%0d lat=%b exp st=2 lat=1", st, latched);
        end
        // A fresh minimum applies: a clear after two ticks must be ignored.
        for (int c = 0; c < 40 && m_el < 2 * BH; c++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++;
        if (act_vec() !== exp_vec() || st !== 2'd2) begin
            n_fail++;
            $display("FAIL retrig_min got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        req = 1'b1;
        step();
        repeat (5) step();
        n_checks++;
        if (act_vec() !== exp_vec() || latched !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre got=%h exp=%h", act_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (led !== 8'h00 || st !== 2'd0 || latched !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now got led=%h st=%0d lat=%b exp led=00 st=0 lat=0",
                     led, st, latched);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; m_el = 0; m_led = '0;
        bounce = 8'h42;
        step();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL areset_post got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            bounce = NL'($urandom);
            if ($urandom_range(0, 29) == 0) req = ~req;
            clr = ($urandom_range(0, 5) == 0);
            ack = ($urandom_range(0, 3) == 0);
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
            end
        end
        req = 1'b0; clr = 1'b0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_ack();
        test_preempt();
        test_priority();
        test_clear_gating();
        test_retrigger();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_led_mode_arbiter
`default_nettype wire
